// File: rtl/imp_pkg.sv
// Shared definitions for the impulse delay / gate-forming chain:
// FSM state encoding, default widths and the tick edge pattern.
package imp_pkg;

   localparam int DEF_W_TICK = 16;
   localparam int DEF_W_CNT  = 8;

   // Oldest..newest across the last three sync flops: low, low, high.
   localparam logic [2:0] TICK_PAT = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/imp_gate_former_tick_sync_edge.sv
// Synchronizes the asynchronous tus tick train and emits one-clock tick.
// Ports: clk, rst_n (sync, active-low), tus (async in), tick (strobe out).
module tick_sync_edge
   import imp_pkg::*;
#(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tus,
   output logic tick
);

   // sync[0] is the first capture flop, sync[SYNC_STAGES-1] the oldest.
   logic [SYNC_STAGES-1:0] sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], tus};
      end
   end

   // Two low samples followed by a high one: exactly one strobe per rise.
   assign tick = ({sync[SYNC_STAGES-1],
                   sync[SYNC_STAGES-2],
                   sync[SYNC_STAGES-3]} == TICK_PAT);

endmodule

// File: rtl/imp_gate_former.sv
// Turns a delayed impulse edge into a burst of tick-timed gate pulses.
// Ports: clk, rst_n (sync, active-low), i_imp (level), tus (async ticks),
//   cfg_width/cfg_period (ticks), cfg_count (pulses), cfg_clr_err (strobe),
//   o_gate (registered gate), o_busy, o_done (1-clk), o_err (sticky).
module imp_gate_former
   import imp_pkg::*;
#(
   parameter int W_TICK      = DEF_W_TICK,
   parameter int W_CNT       = DEF_W_CNT,
   parameter int SYNC_STAGES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_imp,
   input  logic              tus,
   input  logic [W_TICK-1:0] cfg_width,
   input  logic [W_TICK-1:0] cfg_period,
   input  logic [W_CNT-1:0]  cfg_count,
   input  logic              cfg_clr_err,
   output logic              o_gate,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam logic [W_TICK-1:0] ONE_T = W_TICK'(1);
   localparam logic [W_CNT-1:0]  ONE_C = W_CNT'(1);

   logic              tick;
   logic              imp_q;
   logic              trig;
   state_t            state;
   state_t            state_n;
   logic [W_TICK-1:0] width_s;
   logic [W_TICK-1:0] low_s;
   logic [W_CNT-1:0]  count_s;
   logic [W_TICK-1:0] tick_cnt;
   logic [W_TICK-1:0] tick_cnt_n;
   logic [W_CNT-1:0]  pulse_cnt;
   logic [W_CNT-1:0]  pulse_cnt_n;

   tick_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .tus   (tus),
      .tick  (tick)
   );

   // Only the rising edge of the strobe level starts anything.
   assign trig = i_imp & ~imp_q;

   always_comb begin
      state_n     = state;
      tick_cnt_n  = tick_cnt;
      pulse_cnt_n = pulse_cnt;
      unique case (state)
         IDLE: begin
            if (trig) begin
               tick_cnt_n  = '0;
               pulse_cnt_n = '0;
               if ((cfg_width != '0) && (cfg_count != '0)) begin
                  state_n = HIGH;
               end else begin
                  state_n = FIN;
               end
            end
         end
         HIGH: begin
            if (tick) begin
               if (tick_cnt == width_s - ONE_T) begin
                  tick_cnt_n = '0;
                  if (pulse_cnt == count_s - ONE_C) begin
                     state_n = FIN;
                  end else begin
                     state_n     = LOW;
                     pulse_cnt_n = pulse_cnt + ONE_C;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + ONE_T;
               end
            end
         end
         LOW: begin
            if (tick) begin
               if (tick_cnt == low_s - ONE_T) begin
                  state_n    = HIGH;
                  tick_cnt_n = '0;
               end else begin
                  tick_cnt_n = tick_cnt + ONE_T;
               end
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         imp_q     <= 1'b0;
         tick_cnt  <= '0;
         pulse_cnt <= '0;
         width_s   <= '0;
         low_s     <= '0;
         count_s   <= '0;
         o_gate    <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         state     <= state_n;
         imp_q     <= i_imp;
         tick_cnt  <= tick_cnt_n;
         pulse_cnt <= pulse_cnt_n;
         // Config is frozen for the whole burst; low length is
         // precomputed so a too-short period still gives one low tick.
         if ((state == IDLE) && trig) begin
            width_s <= cfg_width;
            count_s <= cfg_count;
            if (cfg_period > cfg_width) begin
               low_s <= cfg_period - cfg_width;
            end else begin
               low_s <= ONE_T;
            end
         end
         o_gate <= (state_n == HIGH);
         o_busy <= (state_n == HIGH) || (state_n == LOW);
         o_done <= (state_n == FIN);
         // A retrigger outranks a simultaneous clear.
         if (trig && (state != IDLE)) begin
            o_err <= 1'b1;
         end else if (cfg_clr_err) begin
            o_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imp_gate_former.sv
// Directed bench for imp_gate_former: bursts, degenerate configs,
// retrigger/err handling, reset abort and asynchronous tick phase.
module tb_imp_gate_former;

   logic        clk;
   logic        rst_n;
   logic        i_imp;
   logic        tus;
   logic [15:0] cfg_width;
   logic [15:0] cfg_period;
   logic [7:0]  cfg_count;
   logic        cfg_clr_err;
   logic        o_gate;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   int vecs;
   int errs;
   int done_cnt;
   int rise_cnt;
   int tick_seen;
   int overlap_cnt;
   logic gate_prev;

   imp_gate_former dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_imp       (i_imp),
      .tus         (tus),
      .cfg_width   (cfg_width),
      .cfg_period  (cfg_period),
      .cfg_count   (cfg_count),
      .cfg_clr_err (cfg_clr_err),
      .o_gate      (o_gate),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_done) done_cnt++;
      if (o_done && o_busy) overlap_cnt++;
      if (o_gate && !gate_prev) rise_cnt++;
      gate_prev = o_gate;
      if (dut.tick) tick_seen++;
   end

   // One clean tus pulse, 2 clk high, then enough low time to settle.
   task automatic tick_once();
      @(posedge clk) #1 tus = 1'b1;
      repeat (2) @(posedge clk);
      #1 tus = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic trigger();
      i_imp = 1'b0;
      @(posedge clk) #1 i_imp = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if ({o_gate, o_busy, o_done, o_err} !== 4'b0000) begin
         errs++;
         $display("FAIL reset_outs: got %b want 0000",
                  {o_gate, o_busy, o_done, o_err});
      end
      rst_n = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic test_single();
      int d0;
      cfg_width = 16'd4; cfg_period = 16'd10; cfg_count = 8'd1;
      d0 = done_cnt;
      trigger();
      vecs++;
      if ({o_gate, o_busy} !== 2'b11) begin
         errs++;
         $display("FAIL single_latency: gate/busy %b want 11",
                  {o_gate, o_busy});
      end
      for (int k = 1; k <= 4; k++) begin
         tick_once();
         vecs++;
         if (o_gate !== (k < 4) || o_busy !== (k < 4)) begin
            errs++;
            $display("FAIL single_tick%0d: gate %b busy %b want %b",
                     k, o_gate, o_busy, k < 4);
         end
      end
      vecs++;
      if (done_cnt - d0 !== 1) begin
         errs++;
         $display("FAIL single_done: %0d pulses want 1", done_cnt - d0);
      end
      i_imp = 1'b0;
   endtask

   task automatic test_burst(input bit retrig);
      logic [12:0] exp_g;
      int d0;
      int r0;
      exp_g = 13'b0110001100011;
      cfg_width = 16'd2; cfg_period = 16'd5; cfg_count = 8'd3;
      d0 = done_cnt;
      r0 = rise_cnt;
      trigger();
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) tick_once();
         vecs++;
         if (o_gate !== exp_g[k] || o_busy !== (k < 12)) begin
            errs++;
            $display("FAIL burst_k%0d: gate %b busy %b want %b %b",
                     k, o_gate, o_busy, exp_g[k], k < 12);
         end
         if (retrig && k == 3) begin
            i_imp = 1'b0;
            @(posedge clk) #1 i_imp = 1'b1;
            @(posedge clk) #1;
            vecs++;
            if (o_err !== 1'b1) begin
               errs++;
               $display("FAIL retrig_set: err %b want 1", o_err);
            end
         end
         if (retrig && k == 5) begin
            cfg_clr_err = 1'b1;
            @(posedge clk) #1 cfg_clr_err = 1'b0;
            vecs++;
            if (o_err !== 1'b0) begin
               errs++;
               $display("FAIL retrig_clr: err %b want 0", o_err);
            end
         end
         if (retrig && k == 7) begin
            i_imp = 1'b0;
            @(posedge clk) #1 i_imp = 1'b1;
            cfg_clr_err = 1'b1;
            @(posedge clk) #1 cfg_clr_err = 1'b0;
            vecs++;
            if (o_err !== 1'b1) begin
               errs++;
               $display("FAIL retrig_set_wins: err %b want 1", o_err);
            end
         end
      end
      vecs++;
      if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 3) begin
         errs++;
         $display("FAIL burst_totals: done %0d rises %0d want 1 3",
                  done_cnt - d0, rise_cnt - r0);
      end
      i_imp = 1'b0;
      cfg_clr_err = 1'b1;
      @(posedge clk) #1 cfg_clr_err = 1'b0;
   endtask

   task automatic test_degenerate();
      logic [13:0] exp_g;
      int r0;
      cfg_width = 16'd4; cfg_period = 16'd10; cfg_count = 8'd0;
      r0 = rise_cnt;
      trigger();
      vecs++;
      if ({o_done, o_busy, o_gate} !== 3'b100) begin
         errs++;
         $display("FAIL count0_done: done/busy/gate %b want 100",
                  {o_done, o_busy, o_gate});
      end
      @(posedge clk) #1;
      vecs++;
      if (o_done !== 1'b0) begin
         errs++;
         $display("FAIL count0_done_len: done %b want 0", o_done);
      end
      tick_once();
      tick_once();
      vecs++;
      if (rise_cnt - r0 !== 0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         errs++;
         $display("FAIL count0_quiet: rises %0d busy %b err %b want 0",
                  rise_cnt - r0, o_busy, o_err);
      end
      i_imp = 1'b0;
      exp_g = 14'b01111110111111;
      cfg_width = 16'd6; cfg_period = 16'd4; cfg_count = 8'd2;
      trigger();
      for (int k = 0; k <= 13; k++) begin
         if (k > 0) tick_once();
         vecs++;
         if (o_gate !== exp_g[k]) begin
            errs++;
            $display("FAIL shortlow_k%0d: gate %b want %b",
                     k, o_gate, exp_g[k]);
         end
      end
      i_imp = 1'b0;
   endtask

   task automatic test_reset_abort();
      int d0;
      int r0;
      logic [3:0] exp_g;
      cfg_width = 16'd4; cfg_period = 16'd10; cfg_count = 8'd2;
      trigger();
      tick_once();
      i_imp = 1'b0;
      @(posedge clk) #1 i_imp = 1'b1;
      @(posedge clk) #1;
      vecs++;
      if (o_err !== 1'b1 || o_gate !== 1'b1) begin
         errs++;
         $display("FAIL abort_pre: err %b gate %b want 1 1",
                  o_err, o_gate);
      end
      d0 = done_cnt;
      i_imp = 1'b0;
      rst_n = 1'b0;
      @(posedge clk) #1 rst_n = 1'b1;
      vecs++;
      if ({o_gate, o_busy, o_err} !== 3'b000) begin
         errs++;
         $display("FAIL abort_clear: gate/busy/err %b want 000",
                  {o_gate, o_busy, o_err});
      end
      repeat (5) tick_once();
      vecs++;
      if (done_cnt - d0 !== 0 || o_gate !== 1'b0) begin
         errs++;
         $display("FAIL abort_no_done: done %0d gate %b want 0 0",
                  done_cnt - d0, o_gate);
      end
      exp_g = 4'b0101;
      cfg_width = 16'd1; cfg_period = 16'd2; cfg_count = 8'd2;
      d0 = done_cnt;
      r0 = rise_cnt;
      trigger();
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) tick_once();
         vecs++;
         if (o_gate !== exp_g[k]) begin
            errs++;
            $display("FAIL post_reset_k%0d: gate %b want %b",
                     k, o_gate, exp_g[k]);
         end
      end
      vecs++;
      if (done_cnt - d0 !== 1 || rise_cnt - r0 !== 2) begin
         errs++;
         $display("FAIL post_reset_totals: done %0d rises %0d want 1 2",
                  done_cnt - d0, rise_cnt - r0);
      end
      i_imp = 1'b0;
   endtask

   task automatic test_async_long();
      int d0;
      int r0;
      int t0;
      cfg_width = 16'd2; cfg_period = 16'd4; cfg_count = 8'd1;
      d0 = done_cnt;
      r0 = rise_cnt;
      t0 = tick_seen;
      i_imp = 1'b0;
      @(posedge clk) #1 i_imp = 1'b1;
      for (int p = 0; p < 20; p++) begin
         #($urandom_range(1, 9));
         tus = 1'b1;
         #20;
         tus = 1'b0;
         #($urandom_range(30, 150));
      end
      repeat (1000) @(posedge clk);
      #1;
      vecs++;
      if (tick_seen - t0 !== 20) begin
         errs++;
         $display("FAIL async_ticks: %0d ticks want 20", tick_seen - t0);
      end
      vecs++;
      if (rise_cnt - r0 !== 1 || done_cnt - d0 !== 1 || o_err !== 1'b0) begin
         errs++;
         $display("FAIL long_imp: rises %0d done %0d err %b want 1 1 0",
                  rise_cnt - r0, done_cnt - d0, o_err);
      end
      vecs++;
      if (overlap_cnt !== 0) begin
         errs++;
         $display("FAIL done_busy_overlap: %0d cycles want 0", overlap_cnt);
      end
      i_imp = 1'b0;
   endtask

   initial begin
      vecs = 0; errs = 0;
      done_cnt = 0; rise_cnt = 0; tick_seen = 0; overlap_cnt = 0;
      gate_prev = 1'b0;
      rst_n = 1'b0; i_imp = 1'b0; tus = 1'b0;
      cfg_width = '0; cfg_period = '0; cfg_count = '0;
      cfg_clr_err = 1'b0;
      test_reset();
      test_single();
      test_burst(1'b0);
      test_burst(1'b1);
      test_degenerate();
      test_reset_abort();
      test_async_long();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/imp_gate_former.md
Name: imp_gate_former

Overview:
- Downstream stage of the tick-counted impulse delayer. Consumes its delayed strobe `i_imp`, a level that stays high for many clocks, and the same `tus` tick train.
- Produces a programmable burst of gate pulses on `o_gate`. Pulse width, pulse period and pulse count are all measured in `tus` ticks.
- Sits between the delay stage and the board-level gate/strobe outputs.

Parameters:
- W_TICK, 16, width of the width/period config and the tick counter
- W_CNT, 8, width of the burst pulse-count config and the pulse counter
- SYNC_STAGES, 3, flops in the `tus` synchronizer (minimum 3)

Ports:
- clk  in  1  system clock, single domain
- rst_n  in  1  synchronous reset, active-low
- i_imp  in  1  delayed strobe from the delayer, clk domain, level
- tus  in  1  tick train, asynchronous to clk
- cfg_width  in  W_TICK  high time per pulse, in ticks
- cfg_period  in  W_TICK  pulse period (high + low), in ticks
- cfg_count  in  W_CNT  pulses per burst
- cfg_clr_err  in  1  one-cycle strobe that clears o_err
- o_gate  out  1  gate output, registered
- o_busy  out  1  high from trigger until the burst ends
- o_done  out  1  one-cycle pulse at burst end
- o_err  out  1  sticky retrigger-while-busy flag

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: while rst_n=0 at a clk edge, all of the following go to 0: o_gate, o_busy, o_done, o_err, the FSM state (IDLE), all counters and the sync flops.
  - Reset mid-burst aborts the burst immediately.
  - No o_done is issued for an aborted burst.
- `tus` handling: synchronize through SYNC_STAGES flops. A tick is the pattern 0→0→1 across the last three flops, giving one `tick` strobe per tus rising edge.
- Trigger: `i_imp` is registered once. A trigger is a rising edge, i.e. i_imp=1 while the previous sample was 0. Only the edge counts; the level is ignored.
- On trigger in IDLE: latch cfg_width, cfg_period and cfg_count into shadow registers. Config changes during a burst have no effect.
- FSM states: IDLE, HIGH, LOW, FIN.
  - IDLE → HIGH on trigger with width≠0 and count≠0.
    - o_gate=1 and o_busy=1 on the cycle after the trigger edge (latency 1 clk).
    - tick_cnt=0, pulse_cnt=0.
  - IDLE → FIN on trigger with width=0 or count=0. No gate is produced; o_busy stays 0.
  - HIGH: tick_cnt increments on each tick.
    - When a tick arrives with tick_cnt=width-1, o_gate drops on the next edge.
    - Then, if pulse_cnt=count-1, go to FIN.
    - Otherwise go to LOW with tick_cnt=0 and pulse_cnt+1.
  - LOW: low length = period-width ticks. If period≤width, the low length is forced to 1 tick.
    - On the last low tick, go to HIGH with o_gate=1 and tick_cnt=0.
  - FIN: for one cycle o_done=1 and o_busy=0, then return to IDLE.
    - No low phase follows the last pulse.
- Ticks arriving in IDLE or FIN are ignored.
- Retrigger: a trigger edge in HIGH, LOW or FIN sets o_err=1 and is otherwise ignored; the burst continues.
- o_err clears only on cfg_clr_err=1 or reset. If cfg_clr_err and a retrigger occur in the same cycle, set wins.
- Counter arithmetic is unsigned. Counters never wrap in normal operation, because compare-equal terminates each phase. Widths follow the parameters.
- Full-scale case: width=2^W_TICK-1 is legal and must terminate correctly.

Decomposition:
- Shared package `imp_pkg` holds:
  - the FSM state enum (IDLE/HIGH/LOW/FIN)
  - default widths W_TICK and W_CNT
  - the tick-edge pattern constant 3'b001, shared with the delayer
- One natural sub-module: `tick_sync_edge`, the SYNC_STAGES synchronizer plus rising-edge detect producing the `tick` strobe.
  - The delayer and later stages can reuse it.

Test Plan:
- Single pulse (width=4, period=10, count=1, tus every 8 clk, trigger):
  - o_gate high 1 clk after the trigger edge, for exactly 4 ticks.
  - One o_done pulse follows; o_busy falls with o_done.
- Burst (width=2, period=5, count=3):
  - Three gates of 2 ticks each, separated by 3 low ticks.
  - o_done follows the 3rd fall with no trailing low phase.
  - Total busy span is 12 ticks.
- Degenerate config:
  - count=0 → o_done 1 clk later, o_gate and o_busy stay 0.
  - width=6, period=4 → the low phase is exactly 1 tick.
- Retrigger: second i_imp rising edge during LOW → o_err=1 and the burst is unchanged. cfg_clr_err clears o_err; a clr coinciding with a new retrigger leaves o_err=1.
- Reset mid-burst: rst_n=0 for 1 clk during HIGH → o_gate, o_busy, o_err all 0 next edge, and no o_done. A new trigger then runs a full burst normally.
- Async tus / long i_imp: tus with random phase and 2-clk high time → exactly one tick per edge. Holding i_imp high for 1000 clk → only one burst.
